// File: rtl/sprite_blitter.sv
// CHIP-8 DXYN sprite draw engine: fetches sprite rows from cpu_memory
// and XORs them into the 64x32 packed framebuffer, flagging collisions.
module sprite_blitter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        fb_en,
  output logic        fb_write,
  output logic [7:0]  fb_addr,
  output logic [7:0]  fb_wdata,
  input  logic [7:0]  fb_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MEM,
    S_WL,
    S_RR,
    S_WR,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [3:0]  n_q, n_d;
  logic [11:0] i_q, i_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  s_q, s_d;
  logic        col_q, col_d;
  logic [11:0] maddr_q, maddr_d;

  logic [2:0]  sh;
  logic [3:0]  row_inc;
  logic        last_row;
  logic [4:0]  fb_row;
  logic [2:0]  col0;
  logic [2:0]  col1;
  logic [15:0] wide;
  logic [7:0]  pix_l;
  logic [7:0]  pix_r;

  assign sh       = x_q[2:0];
  assign row_inc  = row_q + 4'd1;
  assign last_row = (row_inc == n_q);
  assign fb_row   = y_q + {1'b0, row_q};
  assign col0     = x_q[5:3];
  assign col1     = col0 + 3'd1;
  // Upper byte lands in the left column, spill-over in the right one.
  assign wide     = {s_q, 8'h00} >> sh;
  assign pix_l    = wide[15:8];
  assign pix_r    = wide[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (n == 4'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_MEM;
      S_MEM:   state_d = S_WL;
      S_WL: begin
        if (sh != 3'd0) begin
          state_d = S_RR;
        end else begin
          state_d = last_row ? S_DONE : S_FETCH;
        end
      end
      S_RR:    state_d = S_WR;
      S_WR:    state_d = last_row ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      row_q   <= '0;
      s_q     <= '0;
      col_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      i_q     <= i_d;
      row_q   <= row_d;
      s_q     <= s_d;
      col_q   <= col_d;
      maddr_q <= maddr_d;
    end
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    i_d     = i_q;
    row_d   = row_q;
    s_d     = s_q;
    col_d   = col_q;
    maddr_d = maddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          n_d     = n;
          i_d     = i_addr;
          row_d   = 4'd0;
          col_d   = 1'b0;
          maddr_d = (n == 4'd0) ? maddr_q : i_addr;
        end
      end
      S_MEM: s_d = mem_data;
      S_WL: begin
        col_d = col_q | (|(fb_rdata & pix_l));
        if (sh == 3'd0) begin
          row_d = row_inc;
          if (!last_row) begin
            maddr_d = i_q + {8'd0, row_inc};
          end
        end
      end
      S_WR: begin
        col_d = col_q | (|(fb_rdata & pix_r));
        row_d = row_inc;
        if (!last_row) begin
          maddr_d = i_q + {8'd0, row_inc};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    fb_en    = 1'b0;
    fb_write = 1'b0;
    fb_addr  = 8'd0;
    fb_wdata = 8'd0;
    unique case (state_q)
      S_MEM: begin
        fb_en   = 1'b1;
        fb_addr = {fb_row, col0};
      end
      S_WL: begin
        fb_en    = 1'b1;
        fb_write = 1'b1;
        fb_addr  = {fb_row, col0};
        fb_wdata = fb_rdata ^ pix_l;
      end
      S_RR: begin
        fb_en   = 1'b1;
        fb_addr = {fb_row, col1};
      end
      S_WR: begin
        fb_en    = 1'b1;
        fb_write = 1'b1;
        fb_addr  = {fb_row, col1};
        fb_wdata = fb_rdata ^ pix_r;
      end
      default: ;
    endcase
  end

  assign collision = col_q;
  assign mem_addr  = maddr_q;

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Executes the CHIP-8 DXYN draw operation. It reads N sprite bytes from CPU memory through the read-only B port of `cpu_memory` and XORs them into the 64x32 monochrome framebuffer using read-modify-write. It reports whether any lit pixel was cleared (collision, later written to VF). It sits between the CPU core, which issues `start`, `cpu_memory` port B, and the framebuffer RAM.

## Interface
Parameters: none. Widths are fixed by CHIP-8: 12-bit memory address, 64x32 framebuffer packed 8 px/byte, 256 bytes, MSB = leftmost pixel.

- clk  in  1  single clock for all logic; memory and framebuffer ports use it
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- x  in  6  sprite X coordinate (0..63)
- y  in  5  sprite Y coordinate (0..31)
- n  in  4  row count (0..15)
- i_addr  in  12  sprite base address (register I)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- collision  out  1  set if any 1->0 pixel flip; valid with done and held until next accepted start
- mem_addr  out  12  to `cpu_memory` b_addr
- mem_data  in  8  from `cpu_memory` b_out; valid the cycle after mem_addr is presented
- fb_en  out  1  framebuffer port enable
- fb_write  out  1  framebuffer write enable
- fb_addr  out  8  framebuffer byte address = row*8 + column byte
- fb_wdata  out  8  framebuffer write data
- fb_rdata  in  8  framebuffer read data; valid the cycle after fb_en with fb_write=0

## Operation
- States: IDLE, FETCH, MEM, WL, RR, WR, DONE.
- IDLE: on `start`, latch x, y, n, i_addr; clear collision; row := 0.
  - If n==0, go to DONE.
  - Otherwise go to FETCH.
- FETCH: drive mem_addr = (i_addr + row) mod 4096.
- MEM: capture sprite byte S from mem_data. Issue framebuffer read: fb_addr = {(y+row) mod 32, x[5:3]}, fb_en=1.
- WL: compute L = S >> x[2:0]. Drive fb_write=1 to the same address with fb_wdata = fb_rdata ^ L. Update collision |= |(fb_rdata & L).
  - If x[2:0]==0, go to NEXT handling.
  - Otherwise go to RR.
- RR: issue read at column byte (x[5:3]+1) mod 8, same row.
- WR: compute R = (S << (8 - x[2:0]))[7:0]. Write fb_rdata ^ R to that address; collision |= |(fb_rdata & R).
- NEXT handling, done at the end of WL or WR: row := row+1. If row == n, go to DONE; otherwise go to FETCH.
- DONE: assert done for 1 cycle, then return to IDLE.
- Wrap-around:
  - Pixel coordinates wrap modulo 64 horizontally and 32 vertically; there is no clipping.
  - Memory address wraps at 12 bits.
- fb_en and fb_write are low in every state not listed above. mem_addr holds its last value when unused.

## Timing
- Reset values: busy=0, done=0, collision=0, fb_en=0, fb_write=0, fb_addr=0, fb_wdata=0, mem_addr=0. State is IDLE.
- busy is high from the cycle after start is accepted through the DONE cycle, inclusive.
- `start` while busy is ignored, with no side effects.
- Per row: 3 cycles when x[2:0]==0; 5 cycles otherwise.
- Latency, with start sampled at edge 0:
  - done is high in cycle 1+3N (aligned) or 1+5N (unaligned).
  - n==0: done in cycle 1, no memory or framebuffer access.
- collision updates only in WL/WR. Its final value is stable when done=1 and holds until the next accepted start.
- Reset asserted mid-operation:
  - Aborts immediately and returns to IDLE.
  - No done pulse.
  - Framebuffer writes already committed remain; a write in flight at the reset edge is not issued.
- Simultaneous start and done: start is not accepted in DONE. It must be re-presented in IDLE.

## Test plan
- Aligned draw: mem[0x300]=0xF0, framebuffer clear, start x=8 y=0 n=1 i=0x300 -> fb[1]=0xF0, only one fb write, collision=0, done in cycle 4.
- Unaligned draw: mem[0x300]=0xFF, start x=3 y=2 n=1 -> fb[16]=0x1F, fb[17]=0xE0, collision=0, done in cycle 6.
- Collision: repeat the previous draw -> fb[16]=fb[17]=0x00, collision=1 held after done until the next start.
- Wrap: mem[0xFFF]=0xF0, mem[0x000]=0xF0, start x=62 y=31 n=2 i=0xFFF -> fb[255]=0x03, fb[248]=0xC0, fb[7]=0x03, fb[0]=0xC0, collision=0, done in cycle 11.
- Edge requests: start n=0 -> done in cycle 1, collision=0, fb_en never high. A second start pulse during a 15-row draw is ignored, giving exactly one done pulse.
- Reset mid-op: assert rst_n=0 during row 2 of an n=5 draw -> all outputs 0 next cycle, no done. Rows 0-1 remain written; a fresh start then completes normally.
